// File: rtl/uart_pkg.sv
// Shared UART types and constants: drain FSM encoding, WAIT_BUSY timeout, default byte width.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 8;
  localparam int unsigned WAIT_BUSY_TIMEOUT = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular synchronous FIFO with occupancy count and synchronous flush; shared by the TX and RX buffers.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  rd_pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  empty_c;
  logic                  push;
  logic                  pop;

  // Full blocks a push even when a pop lands in the same cycle; flush discards both.
  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign push      = wr_valid && !full_c && !flush;
  assign pop       = rd_pop && !empty_c && !flush;
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues bytes and drains them one frame at a time into the transmitter.
// Optional level/almost_empty status ports are enabled by defining UART_TX_FIFO_STATUS_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  empty,
  output logic                  idle
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_empty
`endif
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned CW     = ADDR_WIDTH + 1;
  localparam int unsigned WAIT_W = $clog2(WAIT_BUSY_TIMEOUT + 1);

  if (ALMOST_EMPTY_LVL >= DEPTH) begin : g_lvl_check
    $error("ALMOST_EMPTY_LVL must be below the FIFO depth");
  end

  tx_state_e             state;
  tx_state_e             state_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_nxt;
  logic                  start_nxt;
  logic                  pop_c;
  logic                  launch_ok_c;
  logic                  full_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [ADDR_WIDTH:0]   count;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .rd_pop    (pop_c),
    .flush     (flush),
    .rd_data_c (rd_data_c),
    .count     (count),
    .full_c    (full_c)
  );

  assign wr_ready = !full_c;
  assign empty    = (count == '0);
  assign idle     = empty && (state == IDLE) && !tx_busy;

  // A flush in the launch cycle wins over the pop, so a discarded byte never starts.
  assign launch_ok_c = (state == IDLE) && !empty && !tx_busy && !flush;

  // State and registered transmitter-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      tx_start <= start_nxt;
      if (pop_c) begin
        tx_data <= rd_data_c;
      end
    end
  end

  // Next state; WAIT_BUSY gives up after the timeout so a dropped start cannot stall the queue.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch_ok_c) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == WAIT_W'(WAIT_BUSY_TIMEOUT - 1)) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Per-state controls: pop and launch pulse from IDLE, busy-wait timer in WAIT_BUSY.
  always_comb begin
    pop_c     = 1'b0;
    start_nxt = 1'b0;
    wait_nxt  = '0;
    case (state)
      IDLE: begin
        pop_c     = launch_ok_c;
        start_nxt = launch_ok_c;
      end
      WAIT_BUSY: begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
      default: begin
        wait_nxt = '0;
      end
    endcase
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign level = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (count <= CW'(ALMOST_EMPTY_LVL));
    end
  end
`endif

endmodule
